// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated NS/EW phase sequencer with pedestrian walk service.
// Green phases stretch under own-direction demand between MIN_GREEN and
// MAX_GREEN ticks and yield only when the cross street or a pedestrian waits.
module traffic_phase_scheduler #(
    parameter int unsigned TICK_DIV  = 10,
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 10,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_btn,
    output logic [2:0] NS,
    output logic [2:0] EW,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [2:0] StNsG  = 3'd0;
    localparam logic [2:0] StNsY  = 3'd1;
    localparam logic [2:0] StRedA = 3'd2;
    localparam logic [2:0] StEwG  = 3'd3;
    localparam logic [2:0] StEwY  = 3'd4;
    localparam logic [2:0] StRedB = 3'd5;
    localparam logic [2:0] StWalk = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] timer_q, timer_d;
    logic        ns_req_q, ns_req_d;
    logic        ew_req_q, ew_req_d;
    logic        ped_req_q, ped_req_d;
    logic        next_dir_q, next_dir_d;  // 1: serve EW after walk, 0: serve NS

    logic        tick;
    logic [31:0] timer_nx;
    logic        is_green;

    assign tick     = (32'(presc_q) == TICK_DIV - 32'd1);
    // Elapsed ticks including the one completing this cycle.
    assign timer_nx = 32'(timer_q) + 32'd1;
    assign is_green = (state_q == StNsG) || (state_q == StEwG);

    // Phase sequencing; exits are evaluated on tick cycles with the latched requests.
    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            StNsG: begin
                if (tick && timer_nx >= MIN_GREEN && (ew_req_q || ped_req_q) &&
                    (!ns_car || timer_nx >= MAX_GREEN)) begin
                    state_d = StNsY;
                end
            end
            StNsY: if (tick && timer_nx >= YELLOW_T) state_d = StRedA;
            StRedA: begin
                if (tick && timer_nx >= ALLRED_T) begin
                    state_d    = ped_req_q ? StWalk : StEwG;
                    next_dir_d = 1'b1;
                end
            end
            StEwG: begin
                if (tick && timer_nx >= MIN_GREEN && (ns_req_q || ped_req_q) &&
                    (!ew_car || timer_nx >= MAX_GREEN)) begin
                    state_d = StEwY;
                end
            end
            StEwY: if (tick && timer_nx >= YELLOW_T) state_d = StRedB;
            StRedB: begin
                if (tick && timer_nx >= ALLRED_T) begin
                    state_d    = ped_req_q ? StWalk : StNsG;
                    next_dir_d = 1'b0;
                end
            end
            StWalk: begin
                if (tick && timer_nx >= WALK_T) state_d = next_dir_q ? StEwG : StNsG;
            end
            default: state_d = StNsG;
        endcase
    end

    // Prescaler and phase timer restart on every state change.
    always_comb begin
        presc_d = presc_q;
        timer_d = timer_q;
        if (state_d != state_q) begin
            presc_d = '0;
            timer_d = '0;
        end else begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (tick && !(is_green && 32'(timer_q) >= MAX_GREEN)) begin
                timer_d = timer_q + 16'd1;
            end
        end
    end

    // Request latches: set outside the serving state, cleared on entry (clear wins).
    always_comb begin
        ns_req_d  = ns_req_q;
        ew_req_d  = ew_req_q;
        ped_req_d = ped_req_q;
        if (ns_car && state_q != StNsG) ns_req_d = 1'b1;
        if (ew_car && state_q != StEwG) ew_req_d = 1'b1;
        if (ped_btn && state_q != StWalk) ped_req_d = 1'b1;
        if (state_d == StNsG && state_q != StNsG) ns_req_d = 1'b0;
        if (state_d == StEwG && state_q != StEwG) ew_req_d = 1'b0;
        if (state_d == StWalk && state_q != StWalk) ped_req_d = 1'b0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StNsG;
            presc_q    <= '0;
            timer_q    <= '0;
            ns_req_q   <= 1'b0;
            ew_req_q   <= 1'b0;
            ped_req_q  <= 1'b0;
            next_dir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            timer_q    <= timer_d;
            ns_req_q   <= ns_req_d;
            ew_req_q   <= ew_req_d;
            ped_req_q  <= ped_req_d;
            next_dir_q <= next_dir_d;
        end
    end

    // Moore lamp decode from the state register.
    always_comb begin
        NS    = 3'b100;
        EW    = 3'b100;
        walk  = 1'b0;
        phase = state_q;
        case (state_q)
            StNsG:   NS = 3'b001;
            StNsY:   NS = 3'b010;
            StEwG:   EW = 3'b001;
            StEwY:   EW = 3'b010;
            StWalk:  walk = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: expected lamp/phase values are
// queued when stimulus is applied and compared in the cycle they fall due.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ns_car = 1'b0, ew_car = 1'b0, ped_btn = 1'b0;
    logic       all_hi = 1'b0;
    logic [2:0] ns1, ew1, ph1, ns2, ew2, ph2;
    logic       wk1, wk2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        bit         sel;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic [2:0] ph;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk(clk), .reset(reset), .ns_car(ns_car), .ew_car(ew_car), .ped_btn(ped_btn),
        .NS(ns1), .EW(ew1), .walk(wk1), .phase(ph1)
    );

    traffic_phase_scheduler #(
        .TICK_DIV(1), .MIN_GREEN(1), .MAX_GREEN(1), .YELLOW_T(3), .ALLRED_T(1), .WALK_T(5)
    ) dut2 (
        .clk(clk), .reset(reset), .ns_car(all_hi), .ew_car(all_hi), .ped_btn(all_hi),
        .NS(ns2), .EW(ew2), .walk(wk2), .phase(ph2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int cyc, input bit sel, input logic [2:0] ns, input logic [2:0] ew,
                        input logic wk, input logic [2:0] ph, input string tag);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.ns = ns; e.ew = ew; e.wk = wk; e.ph = ph; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int c);
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= c) begin
            e = sb.pop_front();
            if (e.cyc < c) begin
                chk({e.tag, "_missed"}, c, e.cyc);
            end else if (e.sel) begin
                chk({e.tag, "_ns"}, ns2, e.ns);
                chk({e.tag, "_ew"}, ew2, e.ew);
                chk({e.tag, "_walk"}, wk2, e.wk);
                chk({e.tag, "_phase"}, ph2, e.ph);
            end else begin
                chk({e.tag, "_ns"}, ns1, e.ns);
                chk({e.tag, "_ew"}, ew1, e.ew);
                chk({e.tag, "_walk"}, wk1, e.wk);
                chk({e.tag, "_phase"}, ph1, e.ph);
            end
        end
    endtask

    task automatic drain(input string tag);
        chk({tag, "_sb_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    // Reset released 1 time unit after a rising edge; the next falling edge is mid cycle 0.
    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Steady-state phase order with every input held high and unit timings.
    function automatic logic [2:0] seq6(input int c);
        int k;
        if (c <= 1) return 3'd0;
        k = (c - 2) % 20;
        if (k < 3) return 3'd1;
        if (k == 3) return 3'd2;
        if (k < 9) return 3'd6;
        if (k == 9) return 3'd3;
        if (k < 13) return 3'd4;
        if (k == 13) return 3'd5;
        if (k < 19) return 3'd6;
        return 3'd0;
    endfunction

    function automatic logic [6:0] lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    return {3'b001, 3'b100, 1'b0};
            3'd1:    return {3'b010, 3'b100, 1'b0};
            3'd3:    return {3'b100, 3'b001, 1'b0};
            3'd4:    return {3'b100, 3'b010, 1'b0};
            3'd6:    return {3'b100, 3'b100, 1'b1};
            default: return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    // Lamp safety on both instances every cycle out of reset.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            assert ($onehot(ns1) && $onehot(ew1) && (ns1[2] || ew1[2])) else begin
                errors++;
                $error("FAIL inv_dut ns=%b ew=%b expected one-hot with a red", ns1, ew1);
            end
            checks++;
            assert ($onehot(ns2) && $onehot(ew2) && (ns2[2] || ew2[2])) else begin
                errors++;
                $error("FAIL inv_dut2 ns=%b ew=%b expected one-hot with a red", ns2, ew2);
            end
        end
    end

    initial begin
        logic [6:0] l;

        // Idle: NS green rests with no demand.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            push(c, 1'b0, 3'b001, 3'b100, 1'b0, 3'd0, "t1_idle");
            sb_check(c);
        end
        drain("t1");

        // Single EW call, NS at minimum green.
        do_reset();
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            ew_car = (c == 5);
            if (c == 5) begin
                push(39, 1'b0, 3'b001, 3'b100, 1'b0, 3'd0, "t2_nsg_last");
                push(40, 1'b0, 3'b010, 3'b100, 1'b0, 3'd1, "t2_nsy");
                push(69, 1'b0, 3'b010, 3'b100, 1'b0, 3'd1, "t2_nsy_last");
                push(70, 1'b0, 3'b100, 3'b100, 1'b0, 3'd2, "t2_reda");
                push(79, 1'b0, 3'b100, 3'b100, 1'b0, 3'd2, "t2_reda_last");
                push(80, 1'b0, 3'b100, 3'b001, 1'b0, 3'd3, "t2_ewg");
            end
            if (c == 79) chk("t2_ew_req_pending", dut.ew_req_q, 1);
            if (c == 80) chk("t2_ew_req_cleared", dut.ew_req_q, 0);
            sb_check(c);
        end
        ew_car = 1'b0;
        drain("t2");

        // NS demand held: green runs to MAX_GREEN.
        do_reset();
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            ns_car = 1'b1;
            ew_car = (c == 5);
            if (c == 5) begin
                push(99, 1'b0, 3'b001, 3'b100, 1'b0, 3'd0, "t3a_nsg_max");
                push(100, 1'b0, 3'b010, 3'b100, 1'b0, 3'd1, "t3a_nsy");
            end
            sb_check(c);
        end
        ns_car = 1'b0; ew_car = 1'b0;
        drain("t3a");

        // NS demand drops mid-extension: exits at the next tick.
        do_reset();
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            ns_car = (c < 62);
            ew_car = (c == 5);
            if (c == 5) begin
                push(69, 1'b0, 3'b001, 3'b100, 1'b0, 3'd0, "t3b_nsg_last");
                push(70, 1'b0, 3'b010, 3'b100, 1'b0, 3'd1, "t3b_nsy");
            end
            sb_check(c);
        end
        ns_car = 1'b0; ew_car = 1'b0;
        drain("t3b");

        // Pedestrian and EW call together: walk inserted before EW green.
        do_reset();
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            ew_car  = (c == 5);
            ped_btn = (c == 5);
            if (c == 5) begin
                push(40, 1'b0, 3'b010, 3'b100, 1'b0, 3'd1, "t4_nsy");
                push(70, 1'b0, 3'b100, 3'b100, 1'b0, 3'd2, "t4_reda");
                push(79, 1'b0, 3'b100, 3'b100, 1'b0, 3'd2, "t4_reda_last");
                push(80, 1'b0, 3'b100, 3'b100, 1'b1, 3'd6, "t4_walk");
                push(129, 1'b0, 3'b100, 3'b100, 1'b1, 3'd6, "t4_walk_last");
                push(130, 1'b0, 3'b100, 3'b001, 1'b0, 3'd3, "t4_ewg");
            end
            sb_check(c);
        end
        ew_car = 1'b0; ped_btn = 1'b0;
        drain("t4");

        // Asynchronous reset during RED_A drops the pending EW call.
        do_reset();
        for (int c = 0; c < 76; c++) begin
            @(negedge clk);
            ew_car = (c == 5);
            if (c == 5) push(74, 1'b0, 3'b100, 3'b100, 1'b0, 3'd2, "t5_reda");
            sb_check(c);
            if (c == 75) begin
                reset = 1'b0;
                #1;
                chk("t5_async_ns", ns1, 3'b001);
                chk("t5_async_ew", ew1, 3'b100);
                chk("t5_async_phase", ph1, 3'd0);
                chk("t5_async_walk", wk1, 1'b0);
            end
        end
        ew_car = 1'b0;
        drain("t5a");
        do_reset();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            push(c, 1'b0, 3'b001, 3'b100, 1'b0, 3'd0, "t5_no_ew");
            sb_check(c);
        end
        drain("t5b");

        // Unit timings with all inputs high: continuous cycling on the second instance.
        all_hi = 1'b1;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            l = lamps(seq6(c));
            push(c, 1'b1, l[6:4], l[3:1], l[0], seq6(c), "t6_cycle");
            sb_check(c);
        end
        all_hi = 1'b0;
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Demand-actuated phase sequencer for a two-way intersection (NS/EW) with pedestrian service. It replaces fixed-cycle light timing with sensor-driven green extension, minimum and maximum green, and an all-red clearance interval. An all-red walk phase is inserted on request. Drives the same NS/EW 3-bit lamp buses consumed by the intersection lamp drivers.

Parameters:
TICK_DIV, 10, clk cycles per timing tick (>=1)
MIN_GREEN, 4, minimum green duration, ticks (>=1)
MAX_GREEN, 10, maximum green under own-direction extension, ticks (>=MIN_GREEN)
YELLOW_T, 3, yellow duration, ticks (>=1)
ALLRED_T, 1, all-red clearance duration, ticks (>=1)
WALK_T, 5, pedestrian walk duration, ticks (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ns_car  in  1  NS vehicle sensor, level, synchronous to clk
ew_car  in  1  EW vehicle sensor, level, synchronous to clk
ped_btn  in  1  pedestrian button, synchronous to clk, 1-cycle pulse or level
NS  out  3  NS lamps {red,yellow,green}; exactly one bit set
EW  out  3  EW lamps {red,yellow,green}; exactly one bit set
walk  out  1  pedestrian walk lamp
phase  out  3  current state code (debug/observability)

Behaviour:
- States and phase codes: NS_G=0, NS_Y=1, RED_A=2 (after NS), EW_G=3, EW_Y=4, RED_B=5 (after EW), WALK=6.
- Lamp decode (Moore, decoded from the state register): NS_G: NS=001, EW=100. NS_Y: NS=010, EW=100. EW_G: NS=100, EW=001. EW_Y: NS=100, EW=010. RED_A, RED_B, WALK: NS=100, EW=100. walk=1 only in WALK.
- Reset asserted: state=NS_G, NS=001, EW=100, walk=0, phase=0, prescaler=0, timer=0, all request latches cleared. Reset asserted mid-phase aborts the phase immediately (asynchronous).
- Prescaler counts 0..TICK_DIV-1. tick=1 on the cycle where it equals TICK_DIV-1. Prescaler and timer clear on every state change, so a fixed phase of D ticks lasts exactly D*TICK_DIV cycles.
- Timer increments on tick. In green states the timer saturates at MAX_GREEN.
- Request latches:
  - ew_req is set by ew_car=1 in any state except EW_G, and cleared on entry to EW_G.
  - ns_req is the same for NS_G.
  - ped_req is set by ped_btn=1 in any state except WALK, and cleared on entry to WALK.
  - Set and clear in the same cycle: clear wins. A request is ignored if it arrives in the cycle that enters the serving state.
- NS_G exits to NS_Y on a tick cycle where all of the following hold:
  - timer+1 >= MIN_GREEN
  - (ew_req | ped_req) = 1
  - (ns_car = 0 or timer+1 >= MAX_GREEN)
  Otherwise NS_G rests indefinitely. EW_G is symmetric with ns_req and ew_car.
- NS_Y goes to RED_A after YELLOW_T ticks. EW_Y goes to RED_B after YELLOW_T ticks.
- RED_A after ALLRED_T ticks: goes to WALK if ped_req, else EW_G. RED_B is symmetric: WALK if ped_req, else NS_G.
- WALK after WALK_T ticks goes to the green opposite the direction last served (next_dir register, written on RED_A/RED_B exit).
- Requests latched during the current phase are evaluated at the exit tick, using the latch value before that cycle's update.
- Invariant: NS and EW are never both non-red in any cycle.

Test Plan:
1. Defaults; release reset at cycle 0 with no inputs -> NS=001, EW=100, phase=0 held for 500 cycles, walk=0.
2. Defaults; ew_car pulse at cycle 5 -> NS=010 at cycle 40, NS=100/EW=100 at cycle 70, EW=001 at cycle 80, ew_req clears at cycle 80.
3. Defaults; ns_car held 1, ew_car pulse at cycle 5 -> NS green extended; NS_Y entered at cycle 100 (MAX_GREEN). Same run with ns_car dropping at cycle 62 -> NS_Y at cycle 70.
4. Defaults; ped_btn and ew_car pulsed in the same cycle (cycle 5) -> NS_Y at 40, RED_A at 70, WALK (walk=1, both red) at 80-129, EW=001 at cycle 130.
5. Reset pulled low at cycle 75 (during RED_A) -> outputs return to NS=001/EW=100/phase=0 without waiting for clk. The pending ew_req is lost, and EW is not served after release.
6. TICK_DIV=1, MIN_GREEN=MAX_GREEN=1, all inputs held high for 200 cycles -> continuous cycling NS_G, NS_Y, RED_A, WALK, EW_G, EW_Y, RED_B, WALK, NS_G. An assertion checks the lamp one-hot and never-both-non-red invariants every cycle.
